// File: rtl/reset_seq_ctrl.sv
// ----------------------------------------------------------------------------
// reset_seq_ctrl : power-up reset sequencer for DDR, camera and video pipeline
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reset_seq_ctrl #(
    parameter int HOLD_CYC  = 16,
    parameter int CAM_DLY   = 1024,
    parameter int TIMEOUT   = 65535,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       syn_reset,
    input  logic       pll_locked,
    input  logic       ddr_init_done,
    input  logic       cam_init_done,
    input  logic       sw_rst_req,
    output logic       ddr_rst,
    output logic       cam_rst_n,
    output logic       pipe_rst,
    output logic       sys_ready,
    output logic       seq_err,
    output logic [1:0] retry_cnt
);

    localparam int MAX_AB  = (HOLD_CYC > CAM_DLY) ? HOLD_CYC : CAM_DLY;
    localparam int MAX_CNT = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CAM_LAST  = CNT_W'(CAM_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(MAX_CNT);
    // retry_cnt is only two bits wide, so the retry budget is clamped to 3
    localparam logic [1:0]       RETRY_LIMIT = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        REL_DDR   = 3'd2,
        DLY_CAM   = 3'd3,
        REL_CAM   = 3'd4,
        RUN       = 3'd5,
        FAIL      = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       retry_nxt;
    logic             timeout_hit;
    logic             counting;

    logic             ddr_rst_nxt;
    logic             cam_rst_n_nxt;
    logic             pipe_rst_nxt;
    logic             sys_ready_nxt;
    logic             seq_err_nxt;

    // {lock, ddr_done, cam_done} through a two-stage synchronizer
    logic [2:0] sync_meta;
    logic [2:0] sync_q;
    logic       lock_s;
    logic       ddr_done_s;
    logic       cam_done_s;

    always_ff @(posedge clk or posedge syn_reset) begin
        if (syn_reset) begin
            sync_meta <= 3'b000;
            sync_q    <= 3'b000;
        end else begin
            sync_meta <= {pll_locked, ddr_init_done, cam_init_done};
            sync_q    <= sync_meta;
        end
    end

    assign lock_s     = sync_q[2];
    assign ddr_done_s = sync_q[1];
    assign cam_done_s = sync_q[0];

    always_ff @(posedge clk or posedge syn_reset) begin
        if (syn_reset) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            retry_cnt <= 2'd0;
            ddr_rst   <= 1'b1;
            cam_rst_n <= 1'b0;
            pipe_rst  <= 1'b1;
            sys_ready <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            ddr_rst   <= ddr_rst_nxt;
            cam_rst_n <= cam_rst_n_nxt;
            pipe_rst  <= pipe_rst_nxt;
            sys_ready <= sys_ready_nxt;
            seq_err   <= seq_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        retry_nxt   = retry_cnt;
        timeout_hit = 1'b0;

        // lock loss outranks every other event outside FAIL
        if (state != FAIL && !lock_s) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: if (lock_s) state_nxt = HOLD;
                HOLD:      if (cnt == HOLD_LAST) state_nxt = REL_DDR;
                REL_DDR: begin
                    if (ddr_done_s)          state_nxt   = DLY_CAM;
                    else if (cnt == TO_LAST) timeout_hit = 1'b1;
                end
                DLY_CAM:   if (cnt == CAM_LAST) state_nxt = REL_CAM;
                REL_CAM: begin
                    if (cam_done_s)          state_nxt   = RUN;
                    else if (cnt == TO_LAST) timeout_hit = 1'b1;
                end
                RUN:       if (sw_rst_req) state_nxt = HOLD;
                FAIL:      state_nxt = FAIL;
                default:   state_nxt = WAIT_LOCK;
            endcase
        end

        if (timeout_hit) begin
            if (retry_cnt == RETRY_LIMIT) begin
                state_nxt = FAIL;
            end else begin
                state_nxt = HOLD;
                retry_nxt = retry_cnt + 2'd1;
            end
        end

        counting = (state == HOLD) || (state == REL_DDR) ||
                   (state == DLY_CAM) || (state == REL_CAM);
        if (state_nxt != state || !counting) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_TOP) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            cnt_nxt = cnt;
        end

        // outputs decoded from the next state so they change with it
        ddr_rst_nxt   = 1'b1;
        cam_rst_n_nxt = 1'b0;
        pipe_rst_nxt  = 1'b1;
        sys_ready_nxt = 1'b0;
        seq_err_nxt   = 1'b0;
        case (state_nxt)
            REL_DDR, DLY_CAM: ddr_rst_nxt = 1'b0;
            REL_CAM: begin
                ddr_rst_nxt   = 1'b0;
                cam_rst_n_nxt = 1'b1;
            end
            RUN: begin
                ddr_rst_nxt   = 1'b0;
                cam_rst_n_nxt = 1'b1;
                pipe_rst_nxt  = 1'b0;
                sys_ready_nxt = 1'b1;
            end
            FAIL:    seq_err_nxt = 1'b1;
            default: ddr_rst_nxt = 1'b1;
        endcase
    end

endmodule

`default_nettype wire
